led_event_capture: RTL and testbench

LED_EVENT_CAPTURE -- requirements
Module: led_event_capture

---
 rtl/led_event_capture.sv | 133 +++++++++++++
 tb/tb_led_event_capture.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_event_capture.sv
// LED event capture: watches a LED vector for changes (or rising bits),
// timestamps each change and queues it in a show-ahead FIFO. When the FIFO
// is full, further events are counted as dropped, and the next accepted
// entry is tagged so the consumer knows there is a gap before it.
module led_event_capture #(
    parameter int WIDTH  = 5,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16,
    parameter int DROP_W = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [WIDTH-1:0]         LEDS_IN,
    input  logic                     EN,
    input  logic                     MODE,
    input  logic                     CLEAR,
    input  logic                     EVT_READY,
    output logic                     EVT_VALID,
    output logic [WIDTH-1:0]         EVT_DATA,
    output logic [TS_W-1:0]          EVT_TIME,
    output logic                     EVT_LOST,
    output logic                     OVF,
    output logic [DROP_W-1:0]        DROP_COUNT,
    output logic [$clog2(DEPTH):0]   LEVEL
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = WIDTH + TS_W + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // Entry layout: {led value, timestamp, lost flag}
    logic [EW-1:0]     mem [DEPTH];

    logic [WIDTH-1:0]  prev;
    logic [TS_W-1:0]   ts;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic              ovf;
    logic [DROP_W-1:0] drop_count;
    logic              lost_pending;

    logic              hit;
    logic              push_req;
    logic              full;
    logic              pop;
    logic              accept;
    logic              drop;
    logic [EW-1:0]     head;

    // Event detection and push/pop arbitration for the current edge
    always_comb begin
        if (MODE) begin
            hit = |(LEDS_IN & ~prev);
        end else begin
            hit = (LEDS_IN != prev);
        end
        full     = (level == FULL_LEVEL);
        pop      = (level != '0) && EVT_READY && !CLEAR;
        push_req = EN && hit && !CLEAR;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts
        accept   = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    // Show-ahead head of the FIFO; contents are meaningless while empty
    always_comb begin
        head       = mem[rd_ptr];
        EVT_VALID  = (level != '0);
        EVT_DATA   = head[EW-1 -: WIDTH];
        EVT_TIME   = head[TS_W:1];
        EVT_LOST   = head[0];
        OVF        = ovf;
        DROP_COUNT = drop_count;
        LEVEL      = level;
    end

    // Storage array is written only on accepted pushes and needs no reset
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[wr_ptr] <= {LEDS_IN, ts, lost_pending};
        end
    end

    // Control state: history, timestamp, pointers, occupancy, drop tracking
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev         <= '0;
            ts           <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            ovf          <= 1'b0;
            drop_count   <= '0;
            lost_pending <= 1'b0;
        end else begin
            // History always tracks the input, even during a flush
            prev <= LEDS_IN;
            if (CLEAR) begin
                ts           <= '0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                level        <= '0;
                ovf          <= 1'b0;
                drop_count   <= '0;
                lost_pending <= 1'b0;
            end else begin
                ts <= ts + 1'b1;
                if (accept) begin
                    wr_ptr       <= wr_ptr + 1'b1;
                    lost_pending <= 1'b0;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (accept && !pop) begin
                    level <= level + 1'b1;
                end else if (!accept && pop) begin
                    level <= level - 1'b1;
                end
                if (drop) begin
                    ovf          <= 1'b1;
                    lost_pending <= 1'b1;
                    if (drop_count != '1) begin
                        drop_count <= drop_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_led_event_capture.sv
// Testbench for led_event_capture: scenario tasks drive stimulus at the
// falling edge, push expected entries into a queue and compare them as the
// DUT presents them.
module tb_led_event_capture;

    localparam int W  = 5;
    localparam int TW = 16;
    localparam int EW = W + TW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  leds = '0;
    logic          en = 1'b1;
    logic          mode = 1'b0;
    logic          clear = 1'b0;
    logic          ready = 1'b0;
    logic          evt_valid;
    logic [W-1:0]  evt_data;
    logic [TW-1:0] evt_time;
    logic          evt_lost;
    logic          ovf;
    logic [7:0]    drop_count;
    logic [3:0]    level;

    // Second instance with a 4-bit timestamp for the wrap scenario
    logic [W-1:0]  leds2 = '0;
    logic          evt_valid2;
    logic [W-1:0]  evt_data2;
    logic [3:0]    evt_time2;
    logic          evt_lost2;
    logic          ovf2;
    logic [7:0]    drop_count2;
    logic [3:0]    level2;

    int checks = 0;
    int failures = 0;

    logic [EW-1:0] q[$];
    logic [3:0]    q2[$];

    // Cycle counters modelling the timestamp of each instance
    int m_ts = 0;
    int m_ts2 = 0;

    led_event_capture dut (
        .CLK(clk), .RESET(rst), .LEDS_IN(leds), .EN(en), .MODE(mode),
        .CLEAR(clear), .EVT_READY(ready), .EVT_VALID(evt_valid),
        .EVT_DATA(evt_data), .EVT_TIME(evt_time), .EVT_LOST(evt_lost),
        .OVF(ovf), .DROP_COUNT(drop_count), .LEVEL(level)
    );

    led_event_capture #(.TS_W(4)) dut2 (
        .CLK(clk), .RESET(rst), .LEDS_IN(leds2), .EN(1'b1), .MODE(1'b0),
        .CLEAR(1'b0), .EVT_READY(1'b1), .EVT_VALID(evt_valid2),
        .EVT_DATA(evt_data2), .EVT_TIME(evt_time2), .EVT_LOST(evt_lost2),
        .OVF(ovf2), .DROP_COUNT(drop_count2), .LEVEL(level2)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) m_ts <= 0;
        else if (clear) m_ts <= 0;
        else m_ts <= m_ts + 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) m_ts2 <= 0;
        else m_ts2 <= m_ts2 + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic drain(input int budget);
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        for (int i = 0; i < budget; i++) begin
            if (!evt_valid) break;
            got = {evt_data, evt_time, evt_lost};
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL drain_unexpected got=%h exp=none", got);
            end else begin
                exp = q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL drain_entry got=%h exp=%h", got, exp);
                end
            end
            ready = 1'b1;
            @(negedge clk);
        end
        ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL drain_end valid=%b pending=%0d exp valid=0 pending=0", evt_valid, q.size());
        end
        q.delete();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        leds  = '0;
        ready = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || level !== 4'd0 || ovf !== 1'b0 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_state valid=%b level=%0d ovf=%b drop=%0d exp 0/0/0/0", evt_valid, level, ovf, drop_count);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0 || level !== 4'd0) begin
            failures++;
            $display("FAIL idle_10 valid=%b level=%0d exp 0/0", evt_valid, level);
        end
        // Timestamp after 10 idle cycles must be 10
        leds = 5'b00001;
        q.push_back({5'b00001, 16'd10, 1'b0});
        @(negedge clk);
        checks++;
        if (level !== 4'd1) begin
            failures++;
            $display("FAIL idle_first_level got=%0d exp=1", level);
        end
        drain(10);
    endtask

    task automatic test_any_change();
        mode = 1'b0;
        do_clear();
        repeat (3) @(negedge clk);
        leds = 5'b00101;
        q.push_back({5'b00101, 16'd3, 1'b0});
        repeat (3) @(negedge clk);
        leds = 5'b00100;
        q.push_back({5'b00100, 16'd6, 1'b0});
        @(negedge clk);
        checks++;
        if (level !== 4'd2) begin
            failures++;
            $display("FAIL any_change_level got=%0d exp=2", level);
        end
        drain(10);
    endtask

    task automatic test_rising();
        mode = 1'b1;
        do_clear();
        repeat (3) @(negedge clk);
        leds = 5'b00101;
        q.push_back({5'b00101, 16'd3, 1'b0});
        repeat (3) @(negedge clk);
        leds = 5'b00100;
        repeat (2) @(negedge clk);
        checks++;
        if (level !== 4'd1) begin
            failures++;
            $display("FAIL rising_level got=%0d exp=1", level);
        end
        drain(10);
        mode = 1'b0;
    endtask

    task automatic test_overflow();
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        do_clear();
        for (int i = 1; i <= 10; i++) begin
            leds = W'(i);
            if (i <= 8) q.push_back({W'(i), TW'(m_ts), 1'b0});
            @(negedge clk);
        end
        checks++;
        if (level !== 4'd8 || drop_count !== 8'd2 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL overflow_state level=%0d drop=%0d ovf=%b exp 8/2/1", level, drop_count, ovf);
        end
        // Pop one entry to make room
        got = {evt_data, evt_time, evt_lost};
        exp = q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL overflow_pop1 got=%h exp=%h", got, exp);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        // First accepted push after drops carries the lost flag
        leds = 5'h11;
        q.push_back({5'h11, TW'(m_ts), 1'b1});
        @(negedge clk);
        checks++;
        if (level !== 4'd8) begin
            failures++;
            $display("FAIL lost_push_level got=%0d exp=8", level);
        end
        // Full FIFO with simultaneous pop and push
        got = {evt_data, evt_time, evt_lost};
        exp = q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL overflow_pop2 got=%h exp=%h", got, exp);
        end
        ready = 1'b1;
        leds = 5'h12;
        q.push_back({5'h12, TW'(m_ts), 1'b0});
        @(negedge clk);
        ready = 1'b0;
        checks++;
        if (level !== 4'd8 || drop_count !== 8'd2) begin
            failures++;
            $display("FAIL full_push_pop level=%0d drop=%0d exp 8/2", level, drop_count);
        end
        drain(20);
    endtask

    task automatic test_clear();
        // Refill past full so a drop is pending when the flush arrives
        for (int i = 0; i < 9; i++) begin
            leds = W'(20 + i);
            @(negedge clk);
        end
        checks++;
        if (level !== 4'd8 || drop_count !== 8'd3 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL preclear_state level=%0d drop=%0d ovf=%b exp 8/3/1", level, drop_count, ovf);
        end
        clear = 1'b1;
        ready = 1'b1;
        leds  = 5'h1F;
        @(negedge clk);
        clear = 1'b0;
        ready = 1'b0;
        checks++;
        if (level !== 4'd0 || evt_valid !== 1'b0 || ovf !== 1'b0 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL clear_state level=%0d valid=%b ovf=%b drop=%0d exp 0/0/0/0", level, evt_valid, ovf, drop_count);
        end
        // Timestamp restarts at 0 and no lost flag survives the flush
        leds = 5'h0E;
        q.push_back({5'h0E, 16'd0, 1'b0});
        @(negedge clk);
        checks++;
        if (level !== 4'd1) begin
            failures++;
            $display("FAIL post_clear_level got=%0d exp=1", level);
        end
        drain(10);
    endtask

    task automatic test_reset_midstream();
        leds = 5'h01;
        @(negedge clk);
        leds = 5'h02;
        @(negedge clk);
        checks++;
        if (level !== 4'd2) begin
            failures++;
            $display("FAIL midstream_level got=%0d exp=2", level);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (level !== 4'd0 || evt_valid !== 1'b0 || drop_count !== 8'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL async_reset level=%0d valid=%b drop=%0d ovf=%b exp 0/0/0/0", level, evt_valid, drop_count, ovf);
        end
        q.delete();
        leds = 5'h07;
        @(negedge clk);
        rst = 1'b0;
        // First edge after release captures the non-zero input at ts 0
        q.push_back({5'h07, 16'd0, 1'b0});
        @(negedge clk);
        checks++;
        if (level !== 4'd1) begin
            failures++;
            $display("FAIL post_reset_level got=%0d exp=1", level);
        end
        drain(10);
    endtask

    task automatic test_ts_wrap();
        logic [3:0] exp;
        q2.delete();
        for (int i = 0; i < 20; i++) begin
            if (evt_valid2) begin
                checks++;
                if (q2.size() == 0) begin
                    failures++;
                    $display("FAIL wrap_unexpected got=%0d exp=none", evt_time2);
                end else begin
                    exp = q2.pop_front();
                    if (evt_time2 !== exp) begin
                        failures++;
                        $display("FAIL wrap_time got=%0d exp=%0d", evt_time2, exp);
                    end
                end
            end
            leds2 = leds2 ^ 5'b00001;
            q2.push_back(4'(m_ts2));
            @(negedge clk);
        end
        checks++;
        if (evt_valid2 !== 1'b1 || q2.size() != 1) begin
            failures++;
            $display("FAIL wrap_last valid=%b pending=%0d exp 1/1", evt_valid2, q2.size());
        end else begin
            exp = q2.pop_front();
            checks++;
            if (evt_time2 !== exp) begin
                failures++;
                $display("FAIL wrap_last_time got=%0d exp=%0d", evt_time2, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (evt_valid2 !== 1'b0) begin
            failures++;
            $display("FAIL wrap_empty got=%b exp=0", evt_valid2);
        end
    endtask

    initial begin
        test_reset();
        test_any_change();
        test_rising();
        test_overflow();
        test_clear();
        test_reset_midstream();
        test_ts_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
